msu_req_sched: RTL
==================

// Module: msu_req_sched
// PURPOSE
//  Sequences MSU1 register-block requests (data seek, audio track, audio ctrl, volume) toward the MCU.
//  Captures start flags, arbitrates one request at a time over a valid/ack/done handshake, then
//  drives the MSU status_reset/status_set strobe and msu_address_ext write that retire each request.
//  Sits between the msu register block and the MCU command interface; runs on clkin.
// PARAMETERS
//  STROBE_LEN  4        cycles status_reset_we / msu_address_ext_write held high (>=3)
//  GAP_LEN     3        min low cycles after a strobe before the next strobe (>=2)
//  TIMEOUT_CYC 24'hFFFFFF  max WAIT_DONE cycles before forced retirement
// PORTS
//  clkin                 in   1   system clock
//  rst_n                 in   1   asynchronous active-low reset
//  data_start            in   1   level: data seek pending (msu status bit 5)
//  audio_start           in   1   level: track load pending (status bit 6)
//  ctrl_start            in   1   level: audio ctrl pending (status bit 0)
//  volume_latch          in   1   1-cycle pulse: volume written
//  addr_in               in   32  seek address
//  track_in              in   16  track number
//  audio_ctrl_in         in   3   audio ctrl bits
//  volume_in             in   8   volume
//  req_valid             out  1   request presented to MCU
//  req_type              out  2   0=data 1=audio 2=ctrl 3=volume
//  req_payload           out  32  payload captured at grant
//  req_ack               in   1   1-cycle: MCU accepted request
//  mcu_done              in   1   1-cycle: MCU finished request
//  mcu_error             in   1   valid with mcu_done: audio load failed
//  mcu_audio_status      in   2   valid with mcu_done: new audio_status (ctrl requests)
//  status_reset_bits     out  6   to msu
//  status_set_bits       out  6   to msu
//  status_reset_we       out  1   to msu
//  msu_address_ext       out  14  to msu, constant 14'h0000
//  msu_address_ext_write out  1   to msu
//  busy                  out  1   FSM not IDLE
// BEHAVIOUR
//  Reset: all outputs 0, pending flags 0, FSM IDLE, edge registers 0; async assert, sync release.
//  Capture: pending[type] set on rising edge of data/audio/ctrl_start (1-cycle edge reg) or on
//   volume_latch; cleared on grant. Set and clear in same cycle -> stays set (re-serviced later).
//  Arbitration in IDLE, fixed priority data > audio > ctrl > volume; payload sampled at grant:
//   data=addr_in, audio={16'h0,track_in}, ctrl={29'h0,audio_ctrl_in}, volume={24'h0,volume_in}.
//  FSM: IDLE -> REQ (grant cycle +1).
//   REQ: req_valid=1, req_type/payload stable until req_ack. ack -> volume ? GAP : WAIT_DONE.
//   WAIT_DONE: counter from 0; mcu_done -> STROBE; count==TIMEOUT_CYC -> STROBE as error.
//     mcu_done in same cycle as timeout -> treat as mcu_done.
//   STROBE: status bits registered on entry, held STROBE_LEN cycles with status_reset_we=1:
//     data : reset=6'b010000 set=0; msu_address_ext_write=1 alongside.
//     audio: ok -> reset=6'b101000 set=0; error/timeout -> reset=6'b100000 set=6'b001000.
//     ctrl : reset=6'b000111 set={3'b0,mcu_audio_status,1'b0}; timeout -> set=0.
//   GAP: all strobes 0 for GAP_LEN cycles -> IDLE.
//  req_ack outside REQ, mcu_done outside WAIT_DONE: ignored.
//  Start level rising again while same type in flight: new pending, serviced after retirement.
//  Latency: start edge to req_valid = 2 cycles when IDLE.
//  Counters saturate, never wrap. busy = (state != IDLE).
// TESTING
//  data_start 0->1, addr_in=32'h00123456 -> req_valid at +2, type 0, payload 32'h00123456;
//   ack, done -> 4 cycles status_reset_we=1, reset=6'b010000, ext_write=1, then >=3 idle cycles.
//  audio_start and volume_latch same cycle, track 16'h0102, vol 8'hFF -> audio first; done+error ->
//   reset=6'b100000 set=6'b001000; then volume req, payload 32'hFF, no strobe after ack.
//  ctrl_start edge, audio_ctrl_in=3'b011, ack, done with status 2'b11 -> reset=6'b000111 set=6'b000110.
//  audio req acked, no mcu_done, TIMEOUT_CYC=100 -> STROBE at WAIT_DONE cycle 100 with error bits.
//  rst_n low during STROBE -> status_reset_we, ext_write, req_valid 0 immediately; pending cleared.
//  Spurious req_ack in IDLE and mcu_done in REQ -> no state change, no strobe.

Source files
------------

// File: rtl/msu_req_sched_if.sv
// msu_req_sched_if: request/ack/done handshake between the MSU request scheduler and the MCU.
interface msu_req_sched_if;
    logic        req_valid;
    logic [1:0]  req_type;
    logic [31:0] req_payload;
    logic        req_ack;
    logic        mcu_done;
    logic        mcu_error;
    logic [1:0]  mcu_audio_status;
    modport master(output req_valid, req_type, req_payload, input req_ack, mcu_done, mcu_error, mcu_audio_status);
    modport slave(input req_valid, req_type, req_payload, output req_ack, mcu_done, mcu_error, mcu_audio_status);
endinterface

// File: rtl/msu_req_sched.sv
// msu_req_sched: captures MSU1 start flags, issues one MCU request at a time, then retires it
// with a status_reset/status_set strobe and msu_address_ext write.
module msu_req_sched #(
    parameter int          STROBE_LEN  = 4,
    parameter int          GAP_LEN     = 3,
    parameter logic [23:0] TIMEOUT_CYC = 24'hFFFFFF
) (
    input  logic                   clkin,
    input  logic                   rst_n,
    input  logic                   data_start,
    input  logic                   audio_start,
    input  logic                   ctrl_start,
    input  logic                   volume_latch,
    input  logic [31:0]            addr_in,
    input  logic [15:0]            track_in,
    input  logic [2:0]             audio_ctrl_in,
    input  logic [7:0]             volume_in,
    msu_req_sched_if.master        mcu,
    output logic [5:0]             status_reset_bits,
    output logic [5:0]             status_set_bits,
    output logic                   status_reset_we,
    output logic [13:0]            msu_address_ext,
    output logic                   msu_address_ext_write,
    output logic                   busy
);
    localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, WAIT_DONE = 3'd2, STROBE = 3'd3, GAP = 3'd4;
    localparam logic [23:0] SL = 24'(STROBE_LEN - 1);
    localparam logic [23:0] GL = 24'(GAP_LEN - 1);

    logic [2:0]  state;
    logic [3:0]  pend, set_v, clr;
    logic [2:0]  sd;
    logic [23:0] cnt;
    logic [5:0]  rb, sb, nrb, nsb;
    logic [1:0]  typ, g;
    logic [31:0] pay, gpay;
    logic        gnt, err;

    assign set_v = {volume_latch, {ctrl_start, audio_start, data_start} & ~sd};
    assign g     = pend[0] ? 2'd0 : pend[1] ? 2'd1 : pend[2] ? 2'd2 : 2'd3;
    assign gnt   = (state == IDLE) && |pend;
    assign clr   = gnt ? 4'b0001 << g : 4'b0000;
    assign gpay  = g == 2'd0 ? addr_in : g == 2'd1 ? {16'h0, track_in} :
                   g == 2'd2 ? {29'h0, audio_ctrl_in} : {24'h0, volume_in};
    // a timeout is retired exactly like a failed completion
    assign err   = !mcu.mcu_done || mcu.mcu_error;

    always_comb begin
        nrb = typ == 2'd0 ? 6'b010000 : typ == 2'd1 ? (err ? 6'b100000 : 6'b101000) : 6'b000111;
        nsb = typ == 2'd1 ? (err ? 6'b001000 : 6'b000000) :
              (typ == 2'd2 && mcu.mcu_done) ? {3'b0, mcu.mcu_audio_status, 1'b0} : 6'b000000;
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pend  <= '0;
            sd    <= '0;
            cnt   <= '0;
            rb    <= '0;
            sb    <= '0;
            typ   <= '0;
            pay   <= '0;
        end else begin
            sd   <= {ctrl_start, audio_start, data_start};
            pend <= (pend & ~clr) | set_v;
            case (state)
                IDLE: if (gnt) begin
                    state <= REQ;
                    typ   <= g;
                    pay   <= gpay;
                end
                REQ: if (mcu.req_ack) begin
                    state <= typ == 2'd3 ? GAP : WAIT_DONE;
                    cnt   <= '0;
                end
                WAIT_DONE: if (mcu.mcu_done || cnt == TIMEOUT_CYC) begin
                    state <= STROBE;
                    cnt   <= '0;
                    rb    <= nrb;
                    sb    <= nsb;
                end else cnt <= cnt + 24'(cnt != '1);
                STROBE: if (cnt == SL) begin
                    state <= GAP;
                    cnt   <= '0;
                end else cnt <= cnt + 24'd1;
                GAP: if (cnt == GL) state <= IDLE;
                     else cnt <= cnt + 24'd1;
                default: state <= IDLE;
            endcase
        end
    end

    assign mcu.req_valid         = state == REQ;
    assign mcu.req_type          = typ;
    assign mcu.req_payload       = pay;
    assign status_reset_we       = state == STROBE;
    assign status_reset_bits     = status_reset_we ? rb : 6'b0;
    assign status_set_bits       = status_reset_we ? sb : 6'b0;
    assign msu_address_ext       = 14'h0000;
    assign msu_address_ext_write = status_reset_we && typ == 2'd0;
    assign busy                  = state != IDLE;
endmodule
